icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache sitting directly upstream of the fetch stage.
- Serves fetch's word address combinationally on a hit.
- On a miss, deasserts valid and refills one line from backing memory over a request/grant/beat handshake.
- Fetch uses the deasserted valid as its stall source and holds its address until valid returns.

---
 rtl/icache_direct.sv | 120 ++++++++++++
 tb/tb_icache_direct.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache
// Zero-latency hits; a miss stalls fetch while one line refills over req/gnt/beat.
module icache_direct #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        invalidate_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LINES-1:0]   r_valid;
    logic [TAG_W-1:0]       r_tag  [NUM_LINES];
    logic [31:0]            r_data [NUM_LINES*WORDS_PER_LINE];
    logic [31:0]            r_miss_addr;
    logic [OFF_W-1:0]       r_beat;
    logic                   r_kill;
    logic [31:0]            r_hit_cnt;
    logic [31:0]            r_miss_cnt;

    logic [OFF_W-1:0]       w_off;
    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic [IDX_W-1:0]       w_miss_idx;
    logic [TAG_W-1:0]       w_miss_tag;
    logic                   w_idle;
    logic                   w_lookup;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_beat;
    logic                   w_last;

    assign w_off      = addr_i[OFF_W+1:2];
    assign w_idx      = addr_i[OFF_W+IDX_W+1:OFF_W+2];
    assign w_tag      = addr_i[31:32-TAG_W];
    assign w_miss_idx = r_miss_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign w_miss_tag = r_miss_addr[31:32-TAG_W];

    // invalidate_i masks both the hit and the miss start in the same cycle
    assign w_idle   = (r_state == S_IDLE);
    assign w_lookup = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit    = w_idle && req_i && !invalidate_i && w_lookup;
    assign w_miss   = w_idle && req_i && !invalidate_i && !w_lookup;
    assign w_beat   = (r_state == S_FILL) && mem_rvalid_i;
    assign w_last   = w_beat && (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    assign valid_o    = w_hit;
    assign rdata_o    = (w_idle && r_valid[w_idx]) ? r_data[{w_idx, w_off}] : 32'd0;
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_comb begin
        w_state_nxt = r_state;
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_miss) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_miss_addr;
                if (mem_gnt_i) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_beat      <= '0;
            r_kill      <= 1'b0;
            r_miss_addr <= 32'd0;
            r_hit_cnt   <= 32'd0;
            r_miss_cnt  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) begin
                r_miss_addr <= {addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
            if ((r_state == S_REQ) && mem_gnt_i) r_beat <= '0;
            else if (w_beat)                      r_beat <= r_beat + 1'b1;
            // a flush seen mid-refill must keep the incoming line from going valid
            if (w_idle)            r_kill <= 1'b0;
            else if (invalidate_i) r_kill <= 1'b1;
            if (invalidate_i)            r_valid <= '0;
            else if (w_last && !r_kill)  r_valid[w_miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && w_beat) r_data[{w_miss_idx, r_beat}] <= mem_rdata_i;
        if (rst_n_i && w_last) r_tag[w_miss_idx] <= w_miss_tag;
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard bench for icache_direct
// A memory responder with programmable grant delay and beat gaps serves refills.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic        invalidate_i = 1'b0;
    logic [31:0] rdata_o;
    logic        valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int          n_vec = 0;
    int          n_miscmp = 0;
    logic [31:0] sb[$];
    int          gnt_delay = 0;
    int          beat_gap = 0;
    int          cur_beat = -1;
    logic        mem_busy = 1'b0;
    logic [31:0] last_req_addr = 32'd0;
    int          exp_hits = 0;
    int          exp_miss = 0;

    always #5 clk = ~clk;

    icache_direct dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .invalidate_i (invalidate_i),
        .rdata_o      (rdata_o),
        .valid_o      (valid_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    // memory responder: drives just after the rising edge
    initial begin : mem_model
        logic [31:0] a;
        forever begin
            @(posedge clk); #1;
            if (mem_req_o) begin
                mem_busy = 1'b1;
                a = mem_addr_o;
                last_req_addr = a;
                for (int g = 0; g < gnt_delay; g++) begin
                    check("req_hold", 32'(mem_req_o), 32'd1);
                    check("addr_hold", mem_addr_o, a);
                    @(posedge clk); #1;
                end
                mem_gnt_i = 1'b1;
                @(posedge clk); #1;
                mem_gnt_i = 1'b0;
                check("req_drop", 32'(mem_req_o), 32'd0);
                for (int b = 0; b < 4; b++) begin
                    if (b > 0) repeat (beat_gap) begin @(posedge clk); #1; end
                    cur_beat     = b;
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(a + 32'(4 * b));
                    @(posedge clk); #1;
                    mem_rvalid_i = 1'b0;
                end
                cur_beat = -1;
                mem_busy = 1'b0;
            end
        end
    end

    task automatic access(input logic [31:0] a, input int exp_lat);
        int          lat;
        logic [31:0] exp;
        sb.push_back(mem_word(a));
        req_i  = 1'b1;
        addr_i = a;
        lat    = 0;
        forever begin
            @(negedge clk);
            if (valid_o || lat > 300) break;
            lat++;
        end
        if (valid_o) begin
            exp = sb.pop_front();
            check("rdata", rdata_o, exp);
            exp_hits++;
        end else begin
            check("hit_timeout", 32'(valid_o), 32'd1);
            sb.delete();
        end
        check("latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(posedge clk); #1;

        access(32'h0000_0100, 6);  exp_miss++;
        check("cold_mem_addr", last_req_addr, 32'h0000_0100);
        check("cold_miss_cnt", miss_cnt_o, 32'(exp_miss));
        access(32'h0000_010C, 0);
        check("line_hit_miss_cnt", miss_cnt_o, 32'(exp_miss));

        access(32'h0000_0500, 6);  exp_miss++;
        check("evict_mem_addr", last_req_addr, 32'h0000_0500);
        access(32'h0000_0100, 6);  exp_miss++;
        check("evict_miss_cnt", miss_cnt_o, 32'd3);

        gnt_delay = 5;
        beat_gap  = 2;
        access(32'h0000_2040, 1 + (5 + 1) + 4 + 3 * 2);  exp_miss++;
        gnt_delay = 0;
        beat_gap  = 0;
        access(32'h0000_204C, 0);

        // flush at beat 2: line stays invalid, held fetch re-misses
        fork
            access(32'h0000_3000, 12);
            begin
                n = 0;
                while (!(mem_rvalid_i && cur_beat == 2) && n < 100) begin
                    @(posedge clk); #2;
                    n++;
                end
                check("inv_beat2_seen", 32'(n < 100), 32'd1);
                invalidate_i = 1'b1;
                @(posedge clk); #2;
                invalidate_i = 1'b0;
            end
        join
        exp_miss += 2;
        check("inv_fill_miss_cnt", miss_cnt_o, 32'(exp_miss));

        access(32'h0000_0100, 6);  exp_miss++;
        req_i        = 1'b1;
        addr_i       = 32'h0000_0100;
        invalidate_i = 1'b1;
        @(negedge clk);
        check("inv_idle_valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        invalidate_i = 1'b0;
        check("inv_idle_no_miss", miss_cnt_o, 32'(exp_miss));
        access(32'h0000_0100, 6);  exp_miss++;
        check("inv_idle_miss_cnt", miss_cnt_o, 32'(exp_miss));

        req_i  = 1'b1;
        addr_i = 32'h0000_0104;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_hit", 32'(valid_o), 32'd1);
        end
        @(posedge clk); #1;
        req_i = 1'b0;
        exp_hits += 10;
        @(negedge clk);
        check("hit_cnt", hit_cnt_o, 32'(exp_hits));
        repeat (3) @(negedge clk);
        check("idle_hit_cnt", hit_cnt_o, 32'(exp_hits));
        check("idle_miss_cnt", miss_cnt_o, 32'(exp_miss));
        check("idle_mem_req", 32'(mem_req_o), 32'd0);

        // reset after beat 1; remaining beats arrive as strays in IDLE
        @(posedge clk); #1;
        beat_gap = 3;
        req_i    = 1'b1;
        addr_i   = 32'h0000_0700;
        n = 0;
        while (!(mem_rvalid_i && cur_beat == 1) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_beat1_seen", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        rst_n_i = 1'b0;
        req_i   = 1'b0;
        @(posedge clk); #1;
        rst_n_i  = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_rdata", rdata_o, 32'd0);
        check("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
        check("mid_rst_mem_addr", mem_addr_o, 32'd0);
        n = 0;
        while (mem_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stray_done", 32'(mem_busy), 32'd0);
        check("stray_hit_cnt", hit_cnt_o, 32'd0);
        check("stray_miss_cnt", miss_cnt_o, 32'd0);
        beat_gap = 0;
        @(posedge clk); #1;
        access(32'h0000_0700, 6);  exp_miss++;
        check("post_rst_miss_cnt", miss_cnt_o, 32'(exp_miss));
        @(negedge clk);
        check("post_rst_hit_cnt", hit_cnt_o, 32'(exp_hits));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
